alu_multicycle: RTL and testbench



---
 rtl/alu_multicycle.sv | 276 +++++++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Registered ALU: single-cycle logic/arithmetic plus iterative MULTU (shift-add) and DIVU (restoring).
// Optional overflow output is built when ALU_OVERFLOW_EN is defined.

module alu_multicycle_chk (
    input logic clk,
    input logic reset,
    input logic busy,
    input logic done,
    input logic iter
);

    // done and busy are mutually exclusive
    a_busy_done_excl : assert property (@(posedge clk) disable iff (reset) !(busy && done));

    // busy mirrors the ITER state
    a_busy_tracks_iter : assert property (@(posedge clk) disable iff (reset) (busy == iter));

endmodule

module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUop,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    output logic [WIDTH-1:0] ALUresult,
    output logic [WIDTH-1:0] hi,
    output logic             busy,
`ifdef ALU_OVERFLOW_EN
    output logic             done,
    output logic             overflow
`else
    output logic             done
`endif
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_LUI   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] single_op(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_LUI:  r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, (a < b)};
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

`ifdef ALU_OVERFLOW_EN
    function automatic logic ovf_calc(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] r
    );
        logic v;
        case (op)
            OP_ADD:  v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            OP_SUB:  v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            default: v = 1'b0;
        endcase
        return v;
    endfunction
`endif

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   result_r, result_s;
    logic [WIDTH-1:0]   hi_r, hi_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [WIDTH-1:0]   a_r, a_s;     // multiplier / dividend-then-quotient
    logic [WIDTH-1:0]   b_r, b_s;     // multiplicand / divisor
    logic [WIDTH-1:0]   acc_r, acc_s; // product high half / partial remainder
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               div_r, div_s;
`ifdef ALU_OVERFLOW_EN
    logic               ovf_r, ovf_s;
`endif

    logic               is_multi_s;
    logic               last_s;
    logic [WIDTH-1:0]   single_res_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH-1:0]   mul_acc_s;
    logic [WIDTH-1:0]   mul_lo_s;
    logic [WIDTH:0]     div_shift_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   div_rem_s;
    logic [WIDTH-1:0]   div_quo_s;

    assign is_multi_s   = (ALUop == OP_MULTU) || (ALUop == OP_DIVU);
    assign last_s       = (state_r == ITER) && (cnt_r == CNT_LAST);
    assign single_res_s = single_op(ALUop, reg1, reg2);

    // One shift-add multiply step: add multiplicand on multiplier LSB, then shift the pair right
    always_comb begin
        mul_sum_s = {1'b0, acc_r} + (a_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
        mul_acc_s = mul_sum_s[WIDTH:1];
        mul_lo_s  = {mul_sum_s[0], a_r[WIDTH-1:1]};
    end

    // One restoring divide step; a zero divisor naturally yields all-ones quotient and remainder = dividend
    always_comb begin
        div_shift_s = {acc_r, a_r[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, b_r});
        div_rem_s   = div_ge_s ? (div_shift_s[WIDTH-1:0] - b_r) : div_shift_s[WIDTH-1:0];
        div_quo_s   = {a_r[WIDTH-2:0], div_ge_s};
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && is_multi_s) begin
                    state_s = ITER;
                end else begin
                    state_s = IDLE;
                end
            end
            ITER: begin
                if (last_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = ITER;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM output and datapath next-value logic; everything holds unless written
    always_comb begin
        result_s = result_r;
        hi_s     = hi_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        a_s      = a_r;
        b_s      = b_r;
        acc_s    = acc_r;
        cnt_s    = cnt_r;
        div_s    = div_r;
`ifdef ALU_OVERFLOW_EN
        ovf_s    = ovf_r;
`endif
        case (state_r)
            IDLE: begin
                if (start && is_multi_s) begin
                    a_s    = reg1;
                    b_s    = reg2;
                    acc_s  = {WIDTH{1'b0}};
                    cnt_s  = {CNT_W{1'b0}};
                    div_s  = (ALUop == OP_DIVU);
                    busy_s = 1'b1;
                end else if (start) begin
                    result_s = single_res_s;
                    done_s   = 1'b1;
`ifdef ALU_OVERFLOW_EN
                    ovf_s    = ovf_calc(ALUop, reg1, reg2, single_res_s);
`endif
                end else begin
                    done_s = 1'b0;
                end
            end
            ITER: begin
                if (div_r) begin
                    acc_s = div_rem_s;
                    a_s   = div_quo_s;
                end else begin
                    acc_s = mul_acc_s;
                    a_s   = mul_lo_s;
                end
                if (last_s) begin
                    result_s = div_r ? div_quo_s : mul_lo_s;
                    hi_s     = div_r ? div_rem_s : mul_acc_s;
                    busy_s   = 1'b0;
                    done_s   = 1'b1;
                    cnt_s    = {CNT_W{1'b0}};
`ifdef ALU_OVERFLOW_EN
                    ovf_s    = 1'b0;
`endif
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                busy_s = 1'b0;
                cnt_s  = {CNT_W{1'b0}};
            end
        endcase
    end

    // Datapath and output registers; reset discards any partial result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_r <= {WIDTH{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            div_r    <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            ovf_r    <= 1'b0;
`endif
        end else begin
            result_r <= result_s;
            hi_r     <= hi_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            a_r      <= a_s;
            b_r      <= b_s;
            acc_r    <= acc_s;
            cnt_r    <= cnt_s;
            div_r    <= div_s;
`ifdef ALU_OVERFLOW_EN
            ovf_r    <= ovf_s;
`endif
        end
    end

    assign ALUresult = result_r;
    assign hi        = hi_r;
    assign busy      = busy_r;
    assign done      = done_r;
`ifdef ALU_OVERFLOW_EN
    assign overflow  = ovf_r;
`endif

    alu_multicycle_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .busy  (busy_r),
        .done  (done_r),
        .iter  (state_r == ITER)
    );

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: stimulus pushes expected results, a negedge monitor pops on done.
// Overflow checks are compiled in when ALU_OVERFLOW_EN is defined.

module tb_alu_multicycle;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_LUI   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  ALUop;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] ALUresult;
    logic [31:0] hi;
    logic        busy;
    logic        done;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_done = 0;
    int   n_push = 0;
    int   cyc;
    int   bcnt;
    int   saved_done;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ALUop     (ALUop),
        .reg1      (reg1),
        .reg2      (reg2),
        .ALUresult (ALUresult),
        .hi        (hi),
        .busy      (busy),
`ifdef ALU_OVERFLOW_EN
        .done      (done),
        .overflow  (overflow)
`else
        .done      (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] r, input logic [31:0] h, input logic o);
        exp_t e;
        e.res = r;
        e.hi  = h;
        e.ovf = o;
        sb_q.push_back(e);
        n_push++;
    endtask

    task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        ALUop = op;
        reg1  = a;
        reg2  = b;
    endtask

    // Waits for done after an issued start; optional noise re-asserts start during busy
    task automatic wait_done(input bit noise, output int c, output int bc);
        c  = 0;
        bc = 0;
        while (c < 100) begin
            @(posedge clk);
            #1;
            c++;
            if (busy) bc++;
            if (noise && c <= 5) set_in(OP_ADD, 32'h0000_0001, 32'h0000_0001);
            else start = 1'b0;
            if (done) break;
        end
        start = 1'b0;
    endtask

    // Monitor: pop and compare on every done pulse
    always @(negedge clk) begin
        if (!reset && done) begin
            n_done++;
            chk("busy_during_done", {63'd0, busy}, 64'd0);
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                mon_e = sb_q.pop_front();
                chk("ALUresult", {32'd0, ALUresult}, {32'd0, mon_e.res});
                chk("hi", {32'd0, hi}, {32'd0, mon_e.hi});
`ifdef ALU_OVERFLOW_EN
                chk("overflow", {63'd0, overflow}, {63'd0, mon_e.ovf});
`endif
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ALUop = 4'd0;
        reg1  = 32'd0;
        reg2  = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_result", {32'd0, ALUresult}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);

        // back-to-back single-cycle ops
        @(posedge clk); #1;
        set_in(OP_ADD, 32'd5, 32'd7);            push(32'd12, 32'd0, 1'b0);
        @(posedge clk); #1;
        chk("b2b_done1", {63'd0, done}, 64'd1);
        set_in(OP_SUB, 32'd3, 32'd5);            push(32'hFFFF_FFFE, 32'd0, 1'b0);
        @(posedge clk); #1;
        chk("b2b_done2", {63'd0, done}, 64'd1);
        set_in(OP_LUI, 32'hDEAD_BEEF, 32'h0000_1234); push(32'h1234_0000, 32'd0, 1'b0);
        @(posedge clk); #1;
        chk("b2b_done3", {63'd0, done}, 64'd1);
        start = 1'b0;
        @(posedge clk); #1;
        chk("done_drops", {63'd0, done}, 64'd0);

        // MULTU with ignored start pulses during busy
        @(posedge clk); #1;
        set_in(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); push(32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        wait_done(1'b1, cyc, bcnt);
        chk("mul_latency", 64'(cyc), 64'd33);
        chk("mul_busy_cycles", 64'(bcnt), 64'd32);

        // DIVU issued in the done cycle
        set_in(OP_DIVU, 32'd100, 32'd7);         push(32'd14, 32'd2, 1'b0);
        wait_done(1'b0, cyc, bcnt);
        chk("div_latency", 64'(cyc), 64'd33);
        chk("div_busy_cycles", 64'(bcnt), 64'd32);

        // single-cycle op keeps hi
        set_in(OP_AND, 32'h0000_F0F0, 32'h0000_FF00); push(32'h0000_F000, 32'd2, 1'b0);
        wait_done(1'b0, cyc, bcnt);
        chk("and_latency", 64'(cyc), 64'd1);

        // divide by zero
        set_in(OP_DIVU, 32'd9, 32'd0);           push(32'hFFFF_FFFF, 32'd9, 1'b0);
        wait_done(1'b0, cyc, bcnt);
        chk("div0_latency", 64'(cyc), 64'd33);

        // async reset aborts MULTU at iteration 10
        set_in(OP_MULTU, 32'd3, 32'd5);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("abort_result", {32'd0, ALUresult}, 64'd0);
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        saved_done = n_done;
        @(posedge clk); #1 reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("no_done_after_abort", 64'(n_done), 64'(saved_done));
        set_in(OP_ADD, 32'd1, 32'd1);            push(32'd2, 32'd0, 1'b0);
        wait_done(1'b0, cyc, bcnt);
        chk("add_after_abort_latency", 64'(cyc), 64'd1);

`ifdef ALU_OVERFLOW_EN
        @(posedge clk); #1;
        set_in(OP_ADD, 32'h7FFF_FFFF, 32'd1);    push(32'h8000_0000, 32'd0, 1'b1);
        wait_done(1'b0, cyc, bcnt);
        set_in(OP_SUB, 32'h8000_0000, 32'd1);    push(32'h7FFF_FFFF, 32'd0, 1'b1);
        wait_done(1'b0, cyc, bcnt);
        set_in(OP_SLT, 32'd2, 32'd3);            push(32'd1, 32'd0, 1'b0);
        wait_done(1'b0, cyc, bcnt);
`endif

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        @(negedge clk); #1;
        chk("done_count", 64'(n_done), 64'(n_push));
        chk("queue_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
